// File: rtl/ram_fifo_ctrl_pkg.sv
// ram_fifo_ctrl_pkg: default sizing shared by the RAM-backed FIFO controller.
package ram_fifo_ctrl_pkg;
    localparam int FIFO_ADDR_WIDTH = 8;
    localparam int FIFO_DATA_WIDTH = 16;
    localparam int RAM_DEPTH       = 2 ** FIFO_ADDR_WIDTH;
endpackage

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: first-word-fall-through FIFO controller for an external dual-port RAM;
// the RAM's registered read port is the output stage.
module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = FIFO_ADDR_WIDTH,
    parameter int DATA_WIDTH  = FIFO_DATA_WIDTH,
    parameter int AFULL_LEVEL = 240
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  clear_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ADDR_WIDTH:0]   level_o,
    output logic                  almost_full_o,
    output logic [ADDR_WIDTH-1:0] ram_waddr_o,
    output logic [DATA_WIDTH-1:0] ram_wdata_o,
    output logic                  ram_we_o,
    output logic                  ram_wclke_o,
    output logic [DATA_WIDTH-1:0] ram_mask_o,
    output logic [ADDR_WIDTH-1:0] ram_raddr_o,
    output logic                  ram_re_o,
    output logic                  ram_rclke_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i
);
    localparam int LW = ADDR_WIDTH + 1;
    localparam logic [LW-1:0] FULL_LVL  = LW'(2 ** ADDR_WIDTH);
    localparam logic [LW-1:0] AFULL_LVL = LW'(AFULL_LEVEL);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  out_valid_q, out_valid_d;
    logic                  in_ready_q, in_ready_d;
    logic                  afull_q, afull_d;
    logic                  push, issue;

    assign push  = in_valid_i & in_ready_q;
    // A read is issued only into an empty or draining output register, so RDATA holds during stalls.
    assign issue = (level_q != '0) & (~out_valid_q | out_ready_i);

    always_comb begin
        wr_ptr_d    = clear_i ? '0 : wr_ptr_q + ADDR_WIDTH'(push);
        rd_ptr_d    = clear_i ? '0 : rd_ptr_q + ADDR_WIDTH'(issue);
        level_d     = clear_i ? '0 : level_q + LW'(push) - LW'(issue);
        out_valid_d = ~clear_i & (issue | (out_valid_q & ~out_ready_i));
        in_ready_d  = level_d != FULL_LVL;
        afull_d     = level_d >= AFULL_LVL;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            afull_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            afull_q     <= afull_d;
        end
    end

    assign in_ready_o    = in_ready_q;
    assign out_valid_o   = out_valid_q;
    assign out_data_o    = ram_rdata_i;
    assign level_o       = level_q;
    assign almost_full_o = afull_q;
    assign ram_waddr_o   = wr_ptr_q;
    assign ram_wdata_o   = in_data_i;
    assign ram_we_o      = push & ~clear_i;
    assign ram_wclke_o   = 1'b1;
    assign ram_mask_o    = '0;
    assign ram_raddr_o   = rd_ptr_q;
    assign ram_re_o      = issue & ~clear_i;
    assign ram_rclke_o   = 1'b1;
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: randomized bench with a queue-based FIFO model and a behavioural 256x16 RAM.
module tb_ram_fifo_ctrl;
    localparam int AW = 8, DW = 16, DEPTH = 256, AFULL = 240;

    logic          clk_i = 1'b0, rstn_i = 1'b0, clear_i = 1'b0;
    logic          in_valid_i = 1'b0, out_ready_i = 1'b0;
    logic [DW-1:0] in_data_i = '0;
    logic          in_ready_o, out_valid_o, almost_full_o;
    logic [DW-1:0] out_data_o, ram_wdata_o, ram_mask_o;
    logic [AW:0]   level_o;
    logic [AW-1:0] ram_waddr_o, ram_raddr_o;
    logic          ram_we_o, ram_wclke_o, ram_re_o, ram_rclke_o;
    logic [DW-1:0] ram_rdata_i = '0;
    logic [DW-1:0] ram [DEPTH];

    ram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AFULL_LEVEL(AFULL)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .clear_i(clear_i),
        .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .level_o(level_o), .almost_full_o(almost_full_o),
        .ram_waddr_o(ram_waddr_o), .ram_wdata_o(ram_wdata_o), .ram_we_o(ram_we_o),
        .ram_wclke_o(ram_wclke_o), .ram_mask_o(ram_mask_o),
        .ram_raddr_o(ram_raddr_o), .ram_re_o(ram_re_o), .ram_rclke_o(ram_rclke_o),
        .ram_rdata_i(ram_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (ram_we_o) ram[ram_waddr_o] <= ram_wdata_o;
        if (ram_re_o) ram_rdata_i <= ram[ram_raddr_o];
    end

    // Model: words held in the RAM as a queue, plus the single output word.
    logic [DW-1:0] mq[$];
    bit            m_ov;
    logic [DW-1:0] m_od;
    int            n_wr, n_rd;
    int            checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_ov = 0;
        n_wr = 0;
        n_rd = 0;
    endfunction

    function automatic void model_step();
        bit psh, iss;
        if (!rstn_i) return;
        if (clear_i) begin
            model_reset();
            return;
        end
        psh = in_valid_i && (mq.size() < DEPTH);
        iss = (mq.size() > 0) && (!m_ov || out_ready_i);
        if (iss) begin
            m_od = mq.pop_front();
            m_ov = 1;
            n_rd++;
        end else if (m_ov && out_ready_i) m_ov = 0;
        if (psh) begin
            mq.push_back(in_data_i);
            n_wr++;
        end
    endfunction

    task automatic tick();
        @(posedge clk_i);
        model_step();
        #1;
    endtask

    always @(negedge clk_i) begin
        bit e_we, e_re;
        if (rstn_i) begin
            e_we = in_valid_i && (mq.size() < DEPTH) && !clear_i;
            e_re = (mq.size() > 0) && (!m_ov || out_ready_i) && !clear_i;
            chk("in_ready", in_ready_o, mq.size() < DEPTH);
            chk("level", level_o, mq.size());
            chk("almost_full", almost_full_o, mq.size() >= AFULL);
            chk("out_valid", out_valid_o, m_ov);
            if (m_ov) chk("out_data", out_data_o, m_od);
            chk("ram_we", ram_we_o, e_we);
            chk("ram_re", ram_re_o, e_re);
            if (e_we) begin
                chk("ram_waddr", ram_waddr_o, n_wr % DEPTH);
                chk("ram_wdata", ram_wdata_o, in_data_i);
            end
            if (e_re) chk("ram_raddr", ram_raddr_o, n_rd % DEPTH);
            chk("ram_clke", {ram_wclke_o, ram_rclke_o}, 2'b11);
            chk("ram_mask", ram_mask_o, 0);
        end
    end

    task automatic drain_all(input string name);
        int guard = 0;
        in_valid_i  = 0;
        out_ready_i = 1;
        while ((level_o != 0 || out_valid_o) && guard < 2000) begin
            tick();
            guard++;
        end
        chk(name, {level_o != 0, out_valid_o}, 0);
    endtask

    initial begin
        int k, pushed, cyc;
        model_reset();
        #12;
        chk("rst_valid", out_valid_o, 0);
        chk("rst_ready", in_ready_o, 1);
        chk("rst_level", level_o, 0);
        chk("rst_afull", almost_full_o, 0);
        chk("rst_we_re", {ram_we_o, ram_re_o}, 0);
        rstn_i = 1;

        // Single word: visible two cycles after the push.
        out_ready_i = 1;
        in_valid_i  = 1;
        in_data_i   = 16'hA5A5;
        tick();
        in_valid_i = 0;
        chk("sw_level_t1", level_o, 1);
        chk("sw_valid_t1", out_valid_o, 0);
        tick();
        chk("sw_valid_t2", out_valid_o, 1);
        chk("sw_data_t2", out_data_o, 16'hA5A5);
        chk("sw_level_t2", level_o, 0);
        tick();
        chk("sw_drained", out_valid_o, 0);

        // Fill 257 words with a stalled consumer, then drain with random stalls.
        out_ready_i = 0;
        for (int i = 0; i < 257; i++) begin
            in_valid_i = 1;
            in_data_i  = DW'(i);
            tick();
        end
        in_valid_i = 0;
        chk("fill_ready", in_ready_o, 0);
        chk("fill_level", level_o, 256);
        chk("fill_afull", almost_full_o, 1);
        chk("fill_out", {out_valid_o, out_data_o}, {1'b1, 16'h0000});
        k = 0;
        for (int g = 0; g < 3000 && (level_o != 0 || out_valid_o); g++) begin
            out_ready_i = $urandom_range(0, 1) == 1;
            if (out_valid_o && out_ready_i) begin
                chk("drain_order", out_data_o, k);
                k++;
            end
            tick();
        end
        chk("drain_count", k, 257);

        // Continuous streaming across several pointer wraps.
        in_valid_i  = 1;
        out_ready_i = 1;
        for (int i = 0; i < 1000; i++) begin
            in_data_i = DW'(16'h1000 + i);
            if (i >= 2) begin
                chk("stream_valid", out_valid_o, 1);
                chk("stream_data", out_data_o, DW'(16'h1000 + i - 2));
            end
            tick();
        end
        drain_all("stream_drain");

        // Random backpressure on both sides.
        pushed = 0;
        cyc = 0;
        while (pushed < 5000 && cyc < 40000) begin
            in_valid_i  = $urandom_range(0, 9) >= 3;
            in_data_i   = DW'($urandom);
            out_ready_i = $urandom_range(0, 9) >= 3;
            if (in_valid_i && in_ready_o) pushed++;
            tick();
            cyc++;
        end
        chk("random_pushed", pushed, 5000);
        drain_all("random_drain");

        // Asynchronous reset with data in flight.
        out_ready_i = 0;
        in_valid_i  = 1;
        for (int i = 0; i < 5; i++) begin
            in_data_i = DW'(16'h2000 + i);
            tick();
        end
        in_valid_i = 0;
        #2 rstn_i = 0;
        #1;
        chk("arst_valid", out_valid_o, 0);
        chk("arst_ready", in_ready_o, 1);
        chk("arst_level", level_o, 0);
        model_reset();
        tick();
        tick();
        rstn_i = 1;
        tick();

        // Clear overrides a simultaneous push.
        out_ready_i = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid_i = 1;
            in_data_i  = DW'(16'h0100 + i);
            tick();
        end
        in_data_i = 16'h1234;
        clear_i   = 1;
        tick();
        clear_i    = 0;
        in_valid_i = 0;
        chk("clr_level", level_o, 0);
        chk("clr_valid", out_valid_o, 0);
        in_valid_i  = 1;
        in_data_i   = 16'h5678;
        out_ready_i = 1;
        tick();
        in_valid_i = 0;
        tick();
        chk("clr_first_valid", out_valid_o, 1);
        chk("clr_first_data", out_data_o, 16'h5678);
        drain_all("clr_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
